// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam int          FETCH_WORD_SIZE  = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_HALT,
        S_FETCH
    } fetch_state_t;

    // One buffered instruction together with the byte PC it was fetched from.
    typedef struct packed {
        logic [FETCH_WORD_SIZE-1:0] pc;
        logic [FETCH_WORD_SIZE-1:0] instr;
    } buf_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory read port plus decode valid/ready handshake of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int WORD_SIZE      = 32,
    parameter int MEM_ADDR_WIDTH = 16
);
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_rden;
    logic [WORD_SIZE-1:0]      mem_q;
    logic                      instr_valid;
    logic [WORD_SIZE-1:0]      instr_data;
    logic [WORD_SIZE-1:0]      instr_pc;
    logic                      instr_ready;

    modport master (
        output mem_addr, mem_rden, instr_valid, instr_data, instr_pc,
        input  mem_q, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rden, instr_valid, instr_data, instr_pc,
        output mem_q, instr_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} entries; flush beats push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  buf_entry_t    push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output buf_entry_t    head_entry
);
    buf_entry_t    storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign do_push    = push && !flush;
    assign do_pop     = pop && head_valid && !flush;
    assign head_entry = head_valid ? storage[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; count gates visibility, so stale words never escape.
    always_ff @(posedge clk) begin
        if (!rst && do_push) storage[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads processor_memory, feeds decode via a small buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  WORD_SIZE      = FETCH_WORD_SIZE,
    parameter int                  MEM_ADDR_WIDTH = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int                  BUF_DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_addr,
    instr_fetch_unit_if.master   bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] inflight_pc;
    logic                 inflight;
    logic                 issue;
    logic                 deq;
    logic [CW-1:0]        count;
    logic [OW-1:0]        occupancy;
    logic                 head_valid;
    buf_entry_t           head_entry;
    buf_entry_t           push_entry;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr[1:0];

    assign deq       = head_valid & bus.instr_ready;
    // Slots committed after this edge: buffered words, minus the one leaving, plus the one landing.
    assign occupancy = OW'(count) + OW'(inflight) - OW'(deq);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_HALT:  if (en)  state_next = S_FETCH;
            S_FETCH: if (!en) state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
        issue = (state == S_FETCH) && en && !redirect_valid
                && (occupancy < OW'(BUF_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HALT;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_addr[WORD_SIZE-1:2], 2'b00};
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    fetch_pc    <= fetch_pc + WORD_SIZE'(INSTR_BYTES);
                    inflight_pc <= fetch_pc;
                end
            end
        end
    end

    assign push_entry = '{pc: inflight_pc, instr: bus.mem_q};

    // A redirect flushes the buffer, which also drops the response returning this cycle.
    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (deq),
        .count      (count),
        .head_valid (head_valid),
        .head_entry (head_entry)
    );

    assign bus.mem_addr    = fetch_pc[MEM_ADDR_WIDTH+1:2];
    assign bus.mem_rden    = issue;
    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;

endmodule
